seq_signed_mult: RTL and testbench
==================================

// Module: seq_signed_mult
//
// PURPOSE
//   Parametrised sequential shift-add multiplier. Datapath and control sit in one block.
//   Successor to the fixed-width signed multiplier processor. Adds a WIDTH parameter,
//   run-time signed/unsigned mode, a start/busy/done handshake and optional early termination.
//   Operands are converted to magnitudes, multiplied one bit per cycle, then the sign is restored.
//
// PARAMETERS
//   WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
//
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous, active-high reset
//   start        in   1        request; accepted only when ready=1
//   signed_mode  in   1        1: operands two's complement; 0: unsigned (sampled with start)
//   a_in         in   WIDTH    multiplicand (sampled with start)
//   b_in         in   WIDTH    multiplier (sampled with start)
//   ready        out  1        1 in IDLE and DONE; start accepted
//   busy         out  1        1 in LOAD, CALC, FIX
//   done         out  1        1-cycle pulse; product valid
//   product      out  2*WIDTH  result; holds until the next result is written
//
// BEHAVIOUR
//   - Reset: state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers 0.
//   - States and transitions:
//     - IDLE: start -> LOAD; capture a_in, b_in, signed_mode.
//     - LOAD: 1 cycle. mag_a=|a|, mag_b=|b| (WIDTH-bit unsigned magnitudes).
//       - neg_res = signed_mode & (a[MSB]^b[MSB]).
//       - acc=0, cnt=WIDTH. -> CALC.
//     - CALC: each cycle, if mag_b[0] then acc += mag_a << (WIDTH-cnt); mag_b >>= 1; cnt--.
//       - Exits to FIX when cnt reaches 0.
//     - FIX: 1 cycle. product <= neg_res ? -acc : acc. -> DONE.
//     - DONE: done=1 for this cycle only.
//       - start -> LOAD (back-to-back, new operands captured); else -> IDLE.
//   - Latency: done is high in the cycle after the (WIDTH+2)th rising edge following the edge
//     that samples start. That is WIDTH+3 cycles start-to-done (11 for WIDTH=8).
//   - Arithmetic:
//     - |x| = x[MSB] & signed_mode ? -x : x, taken as WIDTH-bit unsigned.
//     - Most-negative -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) and needs no extra bit.
//     - acc is 2*WIDTH bits and never overflows. Signed result always fits 2*WIDTH bits.
//     - Zero result with neg_res=1 gives product=0 (negation of 0).
//   - Boundary conditions:
//     - start while busy=1: ignored, no effect on the current operation.
//     - Input changes after the start edge: no effect (operands captured).
//     - product is not updated until FIX, so the previous result remains readable while busy.
//     - reset asserted mid-operation: immediate return to IDLE; product cleared; no done pulse.
//     - start held high continuously: back-to-back operations; done pulses once per result.
//
// CONFIGURATION
//   SEQ_MULT_EARLY_TERM_EN
//     - Defined: CALC also exits to FIX after any iteration that leaves mag_b == 0.
//       - CALC length = max(1, index of highest set bit of |b| + 1).
//       - Latency = 3 + that length. b=0 -> 4 cycles; b=1 -> 4; b=-128 (W=8) -> 11.
//       - The product is identical to the undefined build.
//     - Undefined: CALC always runs exactly WIDTH cycles; latency is fixed.
//
// TESTING (WIDTH=8 unless noted)
//   1. signed, a=-7 (0xF9), b=6 -> done at cycle 11, product=0xFFD6 (-42); busy high cycles 1..10.
//   2. signed, a=-128, b=-128 -> 0x4000; a=-128, b=127 -> 0xC080 (-16256).
//   3. unsigned, a=0xFF, b=0xFF -> 0xFE01.
//      Same operands signed -> 0x0001.
//   4. Back-to-back: start held high, (3,5) then (-2,4).
//      - done pulses 11 cycles apart; products 15 then 0xFFF8.
//      - start pulses during busy are ignored.
//   5. Reset at CALC cycle 4 -> next cycle state IDLE, product=0, done never pulses.
//      Then a new op (2,3) -> 6.
//   6. SEQ_MULT_EARLY_TERM_EN:
//      - b=0 -> done at cycle 4, product 0.
//      - b=3 -> cycle 5.
//      - Results match the undefined build over 10k random vectors; WIDTH=16 repeats 1-3.

Source files
------------

// File: rtl/seq_signed_mult_if.sv
// Handshake and data bundle for seq_signed_mult.
// The requester drives the master side; the multiplier takes the slave side.
interface seq_signed_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a_in, b_in,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, a_in, b_in,
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_signed_mult.sv
// Sequential shift-add multiplier, signed or unsigned per request.
// The operands are reduced to magnitudes and multiplied one multiplier bit per
// cycle; the sign is then restored in a single fix-up cycle.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN -- when defined, the
// iteration phase stops as soon as no multiplier bits remain to be processed.
module seq_signed_mult #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_signed_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             mode_q,    mode_d;
    logic             neg_q,     neg_d;
    logic [PW-1:0]    mcand_q,   mcand_d;
    logic [WIDTH-1:0] mag_b_q,   mag_b_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [PW-1:0]    product_q, product_d;

    // Magnitude of x; the most negative value maps to 2^(WIDTH-1), which
    // still fits an unsigned WIDTH-bit result.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sm);
        return (sm && x[WIDTH-1]) ? -x : x;
    endfunction

    // Next-state and datapath update for every state.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    mode_d  = bus.signed_mode;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                mcand_d = {{WIDTH{1'b0}}, magnitude(a_q, mode_q)};
                mag_b_d = magnitude(b_q, mode_q);
                neg_d   = mode_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                acc_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = S_CALC;
            end
            S_CALC: begin
                // mcand_q already carries the shift by (WIDTH - cnt).
                if (mag_b_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q - CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
                if ((cnt_d == '0) || (mag_b_d == '0)) begin
                    state_d = S_FIX;
                end
`else
                if (cnt_d == '0) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX: begin
                product_d = neg_q ? -acc_q : acc_q;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mode_q    <= mode_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy    = (state_q == S_LOAD) || (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed bench for seq_signed_mult (WIDTH=8) with a product scoreboard.
// Expected products come from an integer reference multiply; expected
// latency follows the SEQ_MULT_EARLY_TERM_EN setting of the build.
module tb_seq_signed_mult;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [PW-1:0] sb[$];

    seq_signed_mult_if #(.WIDTH(W)) bus ();

    seq_signed_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic m);
        longint ia;
        longint ib;
        ia = m ? longint'($signed(a)) : longint'(a);
        ib = m ? longint'($signed(b)) : longint'(b);
        return PW'(ia * ib);
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b, input logic m);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [W-1:0] mag;
        int len;
        mag = (m && b[W-1]) ? -b : b;
        len = 1;
        for (int i = 0; i < W; i++) if (mag[i]) len = i + 1;
        return 3 + len;
`else
        return W + 3;
`endif
    endfunction

    task automatic check_product(input string tag);
        logic [PW-1:0] exp;
        if (sb.size() == 0) begin
            check({tag, " scoreboard entry"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, " product"}, 32'(bus.product), 32'(exp));
        end
    endtask

    // Issue one op from a negedge, scramble inputs and poke start while busy,
    // then wait for done and compare product and latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input string tag);
        int            lat;
        bit            seen;
        logic [PW-1:0] prev;
        lat  = exp_lat(b, m);
        prev = bus.product;
        sb.push_back(model(a, b, m));
        bus.a_in = a;
        bus.b_in = b;
        bus.signed_mode = m;
        bus.start = 1'b1;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            bus.start = (n == 4) && (lat > 4);
            bus.a_in = W'($urandom);
            bus.b_in = W'($urandom);
            bus.signed_mode = ~m;
            if (bus.done) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(n), 32'(lat));
                check_product(tag);
            end else begin
                check({tag, " busy"}, 32'(bus.busy), 32'd1);
                if (n == 3) check({tag, " product held"}, 32'(bus.product), 32'(prev));
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
        check({tag, " ready after"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int  got;
        int  t0;
        bit  any_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset product", 32'(bus.product), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'hF9, 8'h06, 1'b1, "s -7*6");
        run_op(8'h80, 8'h80, 1'b1, "s -128*-128");
        run_op(8'h80, 8'h7F, 1'b1, "s -128*127");
        run_op(8'hFF, 8'hFF, 1'b0, "u 255*255");
        run_op(8'hFF, 8'hFF, 1'b1, "s -1*-1");
        run_op(8'h00, 8'h80, 1'b1, "s 0*-128");
        run_op(8'h05, 8'h00, 1'b1, "s 5*0");
        run_op(8'hFB, 8'h01, 1'b1, "s -5*1");

        // Back-to-back with start held high throughout.
        sb.push_back(model(8'd3, 8'd5, 1'b1));
        bus.a_in = 8'd3;
        bus.b_in = 8'd5;
        bus.signed_mode = 1'b1;
        bus.start = 1'b1;
        got = 0;
        t0  = 0;
        for (int n = 1; n <= 60 && got < 2; n++) begin
            @(negedge clk);
            if (bus.done) begin
                got++;
                check_product("b2b");
                if (got == 1) begin
                    t0 = n;
                    check("b2b first latency", 32'(n), 32'(exp_lat(8'd5, 1'b1)));
                    bus.a_in = 8'hFE;
                    bus.b_in = 8'd4;
                    sb.push_back(model(8'hFE, 8'd4, 1'b1));
                end else begin
                    check("b2b spacing", 32'(n - t0), 32'(exp_lat(8'd4, 1'b1)));
                    bus.start = 1'b0;
                end
            end else if (got == 1 && n == t0 + 3) begin
                check("b2b product held", 32'(bus.product), 32'(model(8'd3, 8'd5, 1'b1)));
            end
        end
        check("b2b both done", 32'(got), 32'd2);
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b no extra done", 32'(bus.done), 32'd0);

        // Reset in the middle of an operation.
        bus.a_in = 8'd100;
        bus.b_in = 8'h55;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset ready", 32'(bus.ready), 32'd1);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset product", 32'(bus.product), 32'd0);
        reset = 1'b0;
        any_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) any_done = 1'b1;
        end
        check("no done after reset", 32'(any_done), 32'd0);
        run_op(8'd2, 8'd3, 1'b1, "s 2*3 after reset");

        // A few random operands in both modes.
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'(i % 2), $sformatf("rand%0d", i));
        end

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
